// File: rtl/tower_placement_ctrl.sv
// rtl/tower_placement_ctrl.sv - initiator of the per-stage tower draw handshake with debounced key pulses
//
// Purpose: sequences one tower draw per start request (stage 1, 2, 3 in order),
// holds exactly one stage draw enable until its matching done returns, reports
// round completion, and turns raw active-low keys into one-cycle command pulses
// that are only accepted while a draw is in progress.
//
// Ports:
//   clk_i                   system clock, rising edge
//   resetn_i                asynchronous active-low reset
//   key_down_n_i            raw active-low button (unsynchronised)
//   key_right_n_i           raw active-low button (unsynchronised)
//   key_draw_n_i            raw active-low button (unsynchronised)
//   start_i                 one-cycle request to place the next tower
//   stage_k_tower_done_i    completion from the tower drawing block (k = 1..3)
//   go_down_o/go_right_o/go_draw_o  one-cycle user command pulses
//   stage_k_draw_tower_o    registered draw enables, at most one high (k = 1..3)
//   round_done_o            one-cycle pulse when a tower finishes
//   towers_placed_o         completed tower count, saturates at 3
//   busy_o                  high while a draw enable is asserted
module tower_placement_ctrl #(
    parameter int unsigned LOCKOUT = 500000
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       key_down_n_i,
    input  logic       key_right_n_i,
    input  logic       key_draw_n_i,
    input  logic       start_i,
    input  logic       stage_1_tower_done_i,
    input  logic       stage_2_tower_done_i,
    input  logic       stage_3_tower_done_i,
    output logic       go_down_o,
    output logic       go_right_o,
    output logic       go_draw_o,
    output logic       stage_1_draw_tower_o,
    output logic       stage_2_draw_tower_o,
    output logic       stage_3_draw_tower_o,
    output logic       round_done_o,
    output logic [1:0] towers_placed_o,
    output logic       busy_o
);

    localparam logic [19:0] LOCKOUT_C = 20'(LOCKOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t     state_q;
    logic [2:0] en_q;       // one-hot stage enable, bit 0 = stage 1
    logic [1:0] placed_q;
    logic       round_done_q;
    logic       busy_q;

    logic [2:0] done;
    assign done = {stage_3_tower_done_i, stage_2_tower_done_i, stage_1_tower_done_i};

    // Handshake FSM. Masking done with the one-hot enable means only the
    // active stage's completion can end the draw.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            en_q         <= 3'b000;
            placed_q     <= 2'd0;
            round_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && placed_q != 2'd3) begin
                        state_q <= DRAW;
                        en_q    <= 3'b001 << placed_q;
                        busy_q  <= 1'b1;
                    end
                end
                DRAW: begin
                    if (|(en_q & done)) begin
                        state_q      <= FINISH;
                        en_q         <= 3'b000;
                        busy_q       <= 1'b0;
                        round_done_q <= 1'b1;
                        placed_q     <= (placed_q == 2'd3) ? 2'd3 : placed_q + 2'd1;
                    end
                end
                FINISH: begin
                    round_done_q <= 1'b0;
                    state_q      <= (placed_q == 2'd3) ? FULL : IDLE;
                end
                FULL: begin
                    state_q <= FULL;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Key path, bit order {draw, right, down}.
    logic [2:0]       key_n;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;   // synchronised "pressed"
    logic [2:0]       prev_q;    // pressed delayed one cycle for edge detect
    logic [2:0]       go_q;
    logic [2:0]       go_d;
    logic [2:0][19:0] cnt_q;
    logic [2:0][19:0] cnt_d;

    assign key_n = {key_draw_n_i, key_right_n_i, key_down_n_i};

    // A rising edge is accepted only in DRAW with the lockout expired; rejected
    // edges are dropped and leave the running counter untouched.
    always_comb begin
        go_d  = 3'b000;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            go_d[i] = sync2_q[i] && !prev_q[i] && (state_q == DRAW) && (cnt_q[i] == 20'd0);
            if (go_d[i]) begin
                cnt_d[i] = LOCKOUT_C;
            end else if (cnt_q[i] != 20'd0) begin
                cnt_d[i] = cnt_q[i] - 20'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            go_q    <= 3'b000;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            go_q    <= go_d;
            cnt_q   <= cnt_d;
        end
    end

    assign go_down_o            = go_q[0];
    assign go_right_o           = go_q[1];
    assign go_draw_o            = go_q[2];
    assign stage_1_draw_tower_o = en_q[0];
    assign stage_2_draw_tower_o = en_q[1];
    assign stage_3_draw_tower_o = en_q[2];
    assign round_done_o         = round_done_q;
    assign towers_placed_o      = placed_q;
    assign busy_o               = busy_q;

endmodule

// File: tb/tb_tower_placement_ctrl.sv
// tb/tb_tower_placement_ctrl.sv - self-checking bench for tower_placement_ctrl
module tb_tower_placement_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_down_n = 1'b1;
    logic       key_right_n = 1'b1;
    logic       key_draw_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] done = 3'b000;
    logic       go_down, go_right, go_draw;
    logic       en1, en2, en3;
    logic       round_done;
    logic [1:0] towers_placed;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tower_placement_ctrl #(.LOCKOUT(4)) dut (
        .clk_i                (clk),
        .resetn_i             (resetn),
        .key_down_n_i         (key_down_n),
        .key_right_n_i        (key_right_n),
        .key_draw_n_i         (key_draw_n),
        .start_i              (start),
        .stage_1_tower_done_i (done[0]),
        .stage_2_tower_done_i (done[1]),
        .stage_3_tower_done_i (done[2]),
        .go_down_o            (go_down),
        .go_right_o           (go_right),
        .go_draw_o            (go_draw),
        .stage_1_draw_tower_o (en1),
        .stage_2_draw_tower_o (en2),
        .stage_3_draw_tower_o (en3),
        .round_done_o         (round_done),
        .towers_placed_o      (towers_placed),
        .busy_o               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [2:0] done;
        logic [2:0] en;
        logic       busy;
        logic       rd;
        logic [1:0] placed;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] en, input logic b,
                             input logic rd, input logic [1:0] placed, input logic [2:0] go);
        check({tag, " en"}, {29'd0, en3, en2, en1}, {29'd0, en});
        check({tag, " busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, " round_done"}, {31'd0, round_done}, {31'd0, rd});
        check({tag, " placed"}, {30'd0, towers_placed}, {30'd0, placed});
        check({tag, " go"}, {29'd0, go_draw, go_right, go_down}, {29'd0, go});
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        start       = 1'b0;
        done        = 3'b000;
        key_down_n  = 1'b1;
        key_right_n = 1'b1;
        key_draw_n  = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    function automatic logic right_low(input int k);
        return (k >= 10 && k <= 12) || (k >= 14 && k <= 20) || (k >= 30 && k <= 34);
    endfunction

    initial begin
        // start, done, en, busy, round_done, placed
        vecs[0]  = '{1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 2'd1};
        vecs[4]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd1};
        vecs[5]  = '{1'b1, 3'b000, 3'b010, 1'b1, 1'b0, 2'd1};
        vecs[6]  = '{1'b0, 3'b001, 3'b010, 1'b1, 1'b0, 2'd1};
        vecs[7]  = '{1'b0, 3'b100, 3'b010, 1'b1, 1'b0, 2'd1};
        vecs[8]  = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 2'd2};
        vecs[9]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2};
        vecs[10] = '{1'b1, 3'b000, 3'b100, 1'b1, 1'b0, 2'd2};
        vecs[11] = '{1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 2'd3};
        vecs[12] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3};
        vecs[13] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3};
        vecs[14] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3};

        // Reset state
        resetn = 1'b0;
        tick();
        check_all("reset", 3'b000, 1'b0, 1'b0, 2'd0, 3'b000);
        resetn = 1'b1;
        tick();

        // Handshake table: three rounds, wrong dones, start in DRAW/FINISH/FULL
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start;
            done  = vecs[i].done;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].busy,
                      vecs[i].rd, vecs[i].placed, 3'b000);
        end
        start = 1'b0;
        done  = 3'b000;

        // Key pulse and lockout on key_right
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            key_right_n = ~right_low(k);
            tick();
            check($sformatf("lockout go edge%0d", k),
                  {29'd0, go_draw, go_right, go_down},
                  (k == 12 || k == 32) ? 32'd2 : 32'd0);
        end
        key_right_n = 1'b1;

        // Keys gated outside DRAW
        do_reset();
        key_draw_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("idle go_draw %0d", k), {31'd0, go_draw}, 32'd0);
        end
        key_draw_n = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        // Simultaneous draw and down presses both pulse, lockout-free
        key_draw_n = 1'b0;
        key_down_n = 1'b0;
        tick();
        check("simul N", {29'd0, go_draw, go_right, go_down}, 32'd0);
        tick();
        check("simul N+1", {29'd0, go_draw, go_right, go_down}, 32'd0);
        tick();
        check("simul N+2", {29'd0, go_draw, go_right, go_down}, 32'd5);
        tick();
        check("simul N+3", {29'd0, go_draw, go_right, go_down}, 32'd0);
        key_draw_n = 1'b1;
        key_down_n = 1'b1;
        repeat (6) tick();
        // Done and key edge on the same edge
        key_right_n = 1'b0;
        tick();
        tick();
        done = 3'b001;
        tick();
        check_all("done+key", 3'b000, 1'b0, 1'b1, 2'd1, 3'b010);
        done = 3'b000;
        key_right_n = 1'b1;
        tick();
        check_all("after done+key", 3'b000, 1'b0, 1'b0, 2'd1, 3'b000);

        // Async reset mid stage-2 DRAW
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        done = 3'b001;
        tick();
        done = 3'b000;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all("stage2 draw", 3'b010, 1'b1, 1'b0, 2'd1, 3'b000);
        #2;
        resetn = 1'b0;
        #1;
        check_all("async reset", 3'b000, 1'b0, 1'b0, 2'd0, 3'b000);
        #1;
        resetn = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all("post reset start", 3'b001, 1'b1, 1'b0, 2'd0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
